cla_32bit_adder: RTL and testbench
==================================

# cla_32bit_adder

Registered N-bit carry-lookahead adder (default 32 bits) for the datapath. It computes S = A + B + c_in with a two-level lookahead carry network built from 4-bit blocks, and registers the sum and carry-out. It is a leaf arithmetic block instantiated wherever a single-cycle-latency wide adder is needed.

## Interface
- N, default 32: operand/sum width; must be a multiple of 4 in the range 4..64.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  N  operand A; unsigned or two's complement, the bit pattern is the same.
- B  input  N  operand B.
- c_in  input  1  carry into bit 0.
- S  output  N  registered sum, bits [N-1:0].
- c_out  output  1  registered carry out of bit N-1.
- One clock; reset is synchronous and active-high.

## Operation
- Bit level:
  - generate g[i] = A[i] & B[i];
  - propagate p[i] = A[i] ^ B[i];
  - sum bit s[i] = p[i] ^ c[i], with c[0] = c_in.
- 4-bit blocks:
  - Each block computes internal carries c1..c3 by lookahead equations from g, p and its block carry-in.
  - Each block outputs group generate G = g3 | p3g2 | p3p2g1 | p3p2p1g0 and group propagate P = p3p2p1p0.
- Second level:
  - Block carries are c_blk[k+1] = G[k] | P[k]&c_blk[k], with c_blk[0] = c_in.
  - These are computed by a lookahead unit over the N/4 groups, not by rippling from block to block.
- c_out = carry out of the top block.
- Arithmetic is modulo 2^N. {c_out, S} equals the (N+1)-bit zero-extended sum of A + B + c_in.
- No overflow flag. Signed overflow is the caller's responsibility.
- All combinational logic is registered into S and c_out at the clock edge.

## Timing
- Latency is 1 cycle. Inputs sampled at edge t appear on S/c_out after edge t.
- Throughput is one addition per cycle, with no handshake and no stall.
- Reset: when rst = 1 at a rising edge, S <= 0 and c_out <= 0. Reset overrides any input.
- The first valid result is registered at the first edge after rst deasserts.
- Reset asserted mid-stream discards the in-flight result. The output is 0 on the cycle after reset.
- Inputs may change every cycle. Outputs depend only on inputs at the previous edge.
- The combinational path must be the lookahead structure, with depth O(log N) block levels, and must not be a 32-stage ripple chain.

## Structure
- Sub-module cla_4bit:
  - inputs a[3:0], b[3:0], cin;
  - outputs s[3:0], G, P.
  - Instantiate N/4 copies with a generate loop.
- Top level contains the block-carry lookahead unit and the output registers.
- Shared package cla_pkg:
  - localparam BLOCK_W = 4;
  - a function that checks N % BLOCK_W == 0 at elaboration; N not a multiple of 4 is an elaboration error.

## Test plan
- Reset: rst = 1 for 2 cycles with A = 5, B = 10 -> S = 0, c_out = 0. After release -> S = 15, c_out = 0 one cycle later.
- A = 5, B = 10, c_in = 0 -> S = 15, c_out = 0. Same operands with c_in = 1 -> S = 16, c_out = 0.
- A = 30, B = 0xFFFFFFF6 (-10), c_in = 0 -> S = 20, c_out = 1.
- A = 127, B = 0xFFFFFFFF, c_in = 0 -> S = 126, c_out = 1.
- Full carry propagation: A = 0xFFFFFFFF, B = 0, c_in = 1 -> S = 0, c_out = 1. A = 0x0000FFFF, B = 1, c_in = 0 -> S = 0x00010000, c_out = 0.
- Back-to-back random A, B, c_in every cycle for at least 1000 cycles, including a mid-stream rst pulse. Each cycle, {c_out, S} must equal the model A + B + c_in from the previous cycle, or 0 after reset.

Source files
------------

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and width check for the carry-lookahead adder
package cla_pkg;

    localparam int BLOCK_W = 4;

    function automatic bit width_ok(input int n);
        return (n % BLOCK_W == 0) && (n >= 4) && (n <= 64);
    endfunction

endpackage

// File: rtl/cla_32bit_adder_if.sv
// rtl/cla_32bit_adder_if.sv - operand/result bundle for the registered CLA adder
interface cla_32bit_adder_if #(
    parameter int N = 32
);
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         c_in;
    logic [N-1:0] S;
    logic         c_out;

    modport master (
        output A,
        output B,
        output c_in,
        input  S,
        input  c_out
    );

    modport slave (
        input  A,
        input  B,
        input  c_in,
        output S,
        output c_out
    );
endinterface

// File: rtl/cla_4bit.sv
// rtl/cla_4bit.sv - 4-bit lookahead block producing sum plus group generate/propagate
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       G,
    output logic       P
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Internal carries are flat sum-of-products, no ripple inside the block.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;
    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign P = &p;
endmodule

// File: rtl/cla_32bit_adder.sv
// rtl/cla_32bit_adder.sv - registered N-bit adder: 4-bit CLA blocks plus a prefix block-carry network
module cla_32bit_adder
    import cla_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_32bit_adder_if.slave     bus
);
    localparam int NB = N / BLOCK_W;

    generate
        if (!width_ok(N)) begin : g_bad_width
            $fatal(1, "cla_32bit_adder: N must be a multiple of 4 in 4..64");
        end
    endgenerate

    logic [NB-1:0] blk_g;
    logic [NB-1:0] blk_p;
    logic [NB:0]   blk_carry;
    logic [N-1:0]  sum_d;
    logic [N-1:0]  sum_q;
    logic          c_out_d;
    logic          c_out_q;

    genvar k;
    generate
        for (k = 0; k < NB; k++) begin : g_blk
            cla_4bit u_blk (
                .a   (bus.A[k*BLOCK_W +: BLOCK_W]),
                .b   (bus.B[k*BLOCK_W +: BLOCK_W]),
                .cin (blk_carry[k]),
                .s   (sum_d[k*BLOCK_W +: BLOCK_W]),
                .G   (blk_g[k]),
                .P   (blk_p[k])
            );
        end
    endgenerate

    // Kogge-Stone prefix over (G,P) with c_in folded into block 0: log2(NB) levels.
    always_comb begin
        logic [NB-1:0] g_t;
        logic [NB-1:0] p_t;
        logic [NB-1:0] g_n;
        logic [NB-1:0] p_n;
        g_t    = blk_g;
        p_t    = blk_p;
        g_t[0] = blk_g[0] | (blk_p[0] & bus.c_in);
        for (int d = 1; d < NB; d = d * 2) begin
            g_n = g_t;
            p_n = p_t;
            for (int i = d; i < NB; i++) begin
                g_n[i] = g_t[i] | (p_t[i] & g_t[i-d]);
                p_n[i] = p_t[i] & p_t[i-d];
            end
            g_t = g_n;
            p_t = p_n;
        end
        blk_carry = {g_t, bus.c_in};
    end

    assign c_out_d = blk_carry[NB];

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign bus.S     = sum_q;
    assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_cla_32bit_adder.sv
// tb/tb_cla_32bit_adder.sv - scoreboard bench for the registered 32-bit CLA adder
module tb_cla_32bit_adder;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    logic [N:0] exp_q[$];

    cla_32bit_adder_if #(.N(N)) bus ();

    cla_32bit_adder #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic ci, input logic r);
        logic [N:0] e;
        logic [N:0] got;
        bus.A    = a;
        bus.B    = b;
        bus.c_in = ci;
        rst      = r;
        exp_q.push_back(r ? '0 : ({1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci}));
        @(posedge clk);
        #1;
        got = {bus.c_out, bus.S};
        e   = exp_q.pop_front();
        checks++;
        assert (got === e) passes++;
        else $error("FAIL %s got=%h expected=%h", tag, got, e);
    endtask

    initial begin
        rst      = 1'b1;
        bus.A    = '0;
        bus.B    = '0;
        bus.c_in = 1'b0;

        step("reset0", 32'd5, 32'd10, 1'b0, 1'b1);
        step("reset1", 32'd5, 32'd10, 1'b0, 1'b1);
        step("release", 32'd5, 32'd10, 1'b0, 1'b0);
        step("5+10+1", 32'd5, 32'd10, 1'b1, 1'b0);
        step("30-10", 32'd30, 32'hFFFF_FFF6, 1'b0, 1'b0);
        step("127-1", 32'd127, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step("full_prop", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        step("half_prop", 32'h0000_FFFF, 32'd1, 1'b0, 1'b0);
        step("max_max_1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step("zero", 32'd0, 32'd0, 1'b0, 1'b0);
        step("blk_edge", 32'h0FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        step("alt_bits", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        step("msb_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        for (int i = 0; i < 1200; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            a = $urandom;
            b = $urandom;
            if (i % 7 == 3) b = ~a;
            step((i == 601) ? "rand_rst" : "rand", a, b, 1'(($urandom_range(0, 1))),
                 (i == 600 || i == 601));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
